clock_mode_ctrl: RTL

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

---
 rtl/clock_mode_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// Clock-setting front end: debounced buttons, 5 Hz / 1 Hz ticks, RUN/SET mode FSM
// with adjust strobes, auto-repeat, idle timeout back to RUN and a field blink.
module clock_mode_ctrl #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_up_n,
    input  logic       btn_dw_n,
    output logic       tick_1hz,
    output logic       tick_5hz,
    output logic [1:0] select_mode,
    output logic [1:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink,
    output logic [1:0] state_dbg_o
);
    localparam int unsigned PRESC_N = CLK_FREQ / 5;
    localparam int unsigned PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
    localparam int unsigned DBW     = $clog2(DB_CYCLES + 1);
    localparam int unsigned TW      = $clog2(TIMEOUT_S + 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC_N - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  IDLE_LAST  = TW'(TIMEOUT_S - 1);
    localparam int BM = 0;
    localparam int BU = 1;
    localparam int BD = 2;

    typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HOUR = 2'd3} state_e;

    logic [2:0]     sync1_q, sync2_q, db_q, press_q;
    logic [DBW-1:0] db_cnt_q [3];
    logic [PW-1:0]  presc_q;
    logic [2:0]     div_q;
    logic           tick5_d, tick1_d, tick5_q, tick1_q;
    state_e         state_q, state_d;
    logic           rep_up_q, rep_up_d, rep_dn_q, rep_dn_d;
    logic [2:0]     rep_cnt_q, rep_cnt_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic           inc_q, inc_d, dec_q, dec_d, blink_q, blink_d;
    logic           both_low, rep_held;

    // Synchronize, then accept a new level only after DB_CYCLES differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            press_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {btn_dw_n, btn_up_n, btn_mode_n};
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                    press_q[i]  <= ~sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign tick5_d = (presc_q == PRESC_LAST);
    assign tick1_d = tick5_d && (div_q == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            div_q   <= '0;
            tick5_q <= 1'b0;
            tick1_q <= 1'b0;
        end else begin
            presc_q <= tick5_d ? '0 : presc_q + PW'(1);
            if (tick5_d) div_q <= (div_q == 3'd4) ? 3'd0 : div_q + 3'd1;
            tick5_q <= tick5_d;
            tick1_q <= tick1_d;
        end
    end

    assign both_low = ~db_q[BU] & ~db_q[BD];
    assign rep_held = (rep_up_q & ~db_q[BU]) | (rep_dn_q & ~db_q[BD]);

    // Strobes are registered one cycle ahead so repeats line up with tick_5hz.
    always_comb begin
        state_d   = state_q;
        rep_up_d  = rep_up_q;
        rep_dn_d  = rep_dn_q;
        rep_cnt_d = rep_cnt_q;
        idle_d    = idle_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        blink_d   = blink_q;
        if (state_q == RUN) begin
            rep_up_d  = 1'b0;
            rep_dn_d  = 1'b0;
            rep_cnt_d = '0;
            idle_d    = '0;
            if (press_q[BM]) state_d = SET_SEC;
        end else if (press_q[BM]) begin
            case (state_q)
                SET_SEC: state_d = SET_MIN;
                SET_MIN: state_d = SET_HOUR;
                default: state_d = RUN;
            endcase
            rep_up_d  = 1'b0;
            rep_dn_d  = 1'b0;
            rep_cnt_d = '0;
            idle_d    = '0;
        end else begin
            if (both_low) begin
                rep_up_d  = 1'b0;
                rep_dn_d  = 1'b0;
                rep_cnt_d = '0;
            end else if (press_q[BU]) begin
                inc_d     = 1'b1;
                rep_up_d  = 1'b1;
                rep_dn_d  = 1'b0;
                rep_cnt_d = '0;
            end else if (press_q[BD]) begin
                dec_d     = 1'b1;
                rep_up_d  = 1'b0;
                rep_dn_d  = 1'b1;
                rep_cnt_d = '0;
            end else if (rep_held) begin
                if (tick5_d) begin
                    if (rep_cnt_q == 3'd5) begin
                        inc_d = rep_up_q;
                        dec_d = rep_dn_q;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 3'd1;
                    end
                end
            end else begin
                rep_up_d  = 1'b0;
                rep_dn_d  = 1'b0;
                rep_cnt_d = '0;
            end
            if ((|press_q) || rep_up_q || rep_dn_q) begin
                idle_d = '0;
            end else if (tick1_q) begin
                if (idle_q == IDLE_LAST) begin
                    state_d = RUN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
        end
        if (state_d == RUN) blink_d = 1'b0;
        else if (tick5_d)   blink_d = ~blink_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            rep_up_q  <= 1'b0;
            rep_dn_q  <= 1'b0;
            rep_cnt_q <= '0;
            idle_q    <= '0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_up_q  <= rep_up_d;
            rep_dn_q  <= rep_dn_d;
            rep_cnt_q <= rep_cnt_d;
            idle_q    <= idle_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            blink_q   <= blink_d;
        end
    end

    always_comb begin
        field_sel = 2'b00;
        case (state_q)
            SET_MIN:  field_sel = 2'b01;
            SET_HOUR: field_sel = 2'b10;
            default:  field_sel = 2'b00;
        endcase
    end

    assign select_mode = (state_q == RUN) ? 2'b00 : 2'b01;
    assign tick_5hz    = tick5_q;
    assign tick_1hz    = tick1_q;
    assign inc_pulse   = inc_q;
    assign dec_pulse   = dec_q;
    assign blink       = blink_q;
    assign state_dbg_o = state_q;

endmodule
